// File: rtl/tpiu_tx.sv
`default_nettype none
// tpiu_tx: TPIU trace-port transmitter. Packs 16-bit words into 16-byte frames with
// ff ff ff 7f sync and drives DDR-split 4/2/1-bit pin chunks. Rev 1.0
module tpiu_tx #(
  parameter int         SYNC_INTERVAL = 16,
  parameter logic [1:0] WIDTH_RST     = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  width,
  input  logic [15:0] DataIn,
  input  logic        DataValid,
  output logic        DataReady,
  output logic        DataOverf,
  output logic [3:0]  traceDouta,
  output logic [3:0]  traceDoutb,
  output logic        frameStart,
  output logic        syncOut
);

  typedef enum logic [0:0] {ST_SYNC = 1'b0, ST_FRAME = 1'b1} state_t;
  localparam logic [15:0] SYNC_N = 16'(SYNC_INTERVAL);

  logic [15:0] mem [16];
  logic [1:0]  full;
  logic        fill_bank;
  logic        send_bank;
  logic [2:0]  fill_cnt;
  logic        running;
  state_t      state;
  logic [3:0]  byte_idx;
  logic [1:0]  sub;
  logic [1:0]  act_width;
  logic [15:0] frame_cnt;

  logic        accept;
  logic        last_sub;
  logic        seq_end;
  logic        frame_done;
  logic        waiting;
  logic        forced;
  logic        go_frame;
  logic        bank_fills;
  logic [15:0] cur_word;
  logic [7:0]  cur_byte;
  logic [7:0]  shifted;
  logic [3:0]  chunk_a;
  logic [3:0]  chunk_b;
  logic [1:0]  full_next;
  logic        fill_bank_next;

  assign accept     = DataValid && DataReady;
  assign bank_fills = accept && (fill_cnt == 3'd7);
  assign cur_word   = mem[{send_bank, byte_idx[3:1]}];

  always_comb begin
    cur_byte = 8'hff;
    if (state == ST_FRAME)
      cur_byte = byte_idx[0] ? cur_word[15:8] : cur_word[7:0];
    else if (byte_idx[1:0] == 2'd3)
      cur_byte = 8'h7f;
  end

  always_comb begin
    last_sub = 1'b0;
    shifted  = cur_byte;
    chunk_a  = 4'd0;
    chunk_b  = 4'd0;
    case (act_width)
      2'd3: begin
        last_sub = 1'b1;
        chunk_a  = shifted[3:0];
        chunk_b  = shifted[7:4];
      end
      2'd2: begin
        last_sub = (sub[0] == 1'b1);
        shifted  = cur_byte >> {sub[0], 2'b00};
        chunk_a  = {2'b00, shifted[1:0]};
        chunk_b  = {2'b00, shifted[3:2]};
      end
      default: begin
        last_sub = (sub == 2'd3);
        shifted  = cur_byte >> {sub, 1'b0};
        chunk_a  = {3'b000, shifted[0]};
        chunk_b  = {3'b000, shifted[1]};
      end
    endcase
  end

  assign seq_end    = running && last_sub &&
                      (byte_idx == ((state == ST_SYNC) ? 4'd3 : 4'd15));
  assign frame_done = seq_end && (state == ST_FRAME);
  // At a frame end the bank being sent is not a candidate; the other one is.
  assign waiting    = (state == ST_FRAME) ? full[~send_bank] : full[send_bank];
  // The counter increments at this same edge, so compare its incremented value.
  assign forced     = (SYNC_N != 16'd0) && ((frame_cnt + 16'd1) == SYNC_N);
  assign go_frame   = waiting && !((state == ST_FRAME) && forced);

  always_comb begin
    full_next = full;
    if (frame_done)
      full_next[send_bank] = 1'b0;
    if (bank_fills)
      full_next[fill_bank] = 1'b1;
    fill_bank_next = fill_bank ^ bank_fills;
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[{fill_bank, fill_cnt}] <= DataIn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 2'b00;
      fill_bank  <= 1'b0;
      send_bank  <= 1'b0;
      fill_cnt   <= 3'd0;
      running    <= 1'b0;
      state      <= ST_SYNC;
      byte_idx   <= 4'd0;
      sub        <= 2'd0;
      act_width  <= WIDTH_RST;
      frame_cnt  <= 16'd0;
      DataReady  <= 1'b0;
      DataOverf  <= 1'b0;
      traceDouta <= 4'd0;
      traceDoutb <= 4'd0;
      frameStart <= 1'b0;
      syncOut    <= 1'b0;
    end else begin
      running   <= 1'b1;
      full      <= full_next;
      fill_bank <= fill_bank_next;
      DataReady <= !full_next[fill_bank_next];
      DataOverf <= DataValid && !DataReady;
      if (accept)
        fill_cnt <= fill_cnt + 3'd1;
      if (running) begin
        traceDouta <= chunk_a;
        traceDoutb <= chunk_b;
        frameStart <= (state == ST_FRAME) && (byte_idx == 4'd0) && (sub == 2'd0);
        syncOut    <= (state == ST_SYNC);
        if (!last_sub) begin
          sub <= sub + 2'd1;
        end else begin
          sub <= 2'd0;
          if (seq_end) begin
            state     <= go_frame ? ST_FRAME : ST_SYNC;
            byte_idx  <= 4'd0;
            act_width <= width;
          end else begin
            byte_idx <= byte_idx + 4'd1;
          end
        end
        if (frame_done) begin
          send_bank <= ~send_bank;
          frame_cnt <= frame_cnt + 16'd1;
        end
        if (seq_end && (state == ST_SYNC))
          frame_cnt <= 16'd0;
      end
    end
  end

endmodule
`default_nettype wire
